dmem_arbiter: RTL
=================

# dmem_arbiter

Two-requester arbiter and sequencer for the 64-word x 32-bit data memory. It accepts read/write requests from port 0 (CPU load/store path) and port 1 (debug/loader port) and grants one requester at a time. It drives the memory's read-enable, write-enable, address and write-data inputs from registers, captures combinational read data, and returns it with a one-cycle acknowledge. It sits between the pipeline's memory stage, the debug port and the data memory instance.

## Interface
- ADDR_W, 6, memory word-address width (64 words)
- DATA_W, 32, data width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- r0_req / r1_req  in  1  request; held high until the matching ack
- r0_we / r1_we  in  1  1 = write, 0 = read; sampled at grant
- r0_addr / r1_addr  in  ADDR_W  word address; sampled at grant
- r0_wdata / r1_wdata  in  DATA_W  write data; sampled at grant
- r0_ack / r1_ack  out  1  one-cycle completion pulse
- r0_rdata / r1_rdata  out  DATA_W  read result; valid with ack, held until that port's next read completes
- mem_read  out  1  to memory read enable
- mem_write  out  1  to memory write enable
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_rdata  in  DATA_W  from memory read data (combinational in address)
- busy  out  1  high in ACCESS and RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high, select a winner, latch its we/addr/wdata and the granted port id, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS: mem_addr and mem_wdata come from the latched values. Exactly one of mem_read/mem_write is high, per the latched we; they are never both high. Always go to RESP.
- RESP: the granted port's ack is 1. The other port's ack is 0. Go to IDLE.
- Read: the granted port's rdata loads mem_rdata at the edge leaving ACCESS. The other port's rdata is unchanged.
- Write: the memory commits at the edge leaving ACCESS. No rdata changes.
- Arbitration when both ports request in IDLE: round-robin. The grant goes to the port not granted last. last_grant updates on every grant.
- Arbitration when only one port requests: that port wins regardless of last_grant.
- Request fields changing after the grant have no effect on the access in flight.
- The requester must drop req in the cycle after ack. A req still high in the following IDLE is treated as a new request.
- Outputs are 0 outside ACCESS: mem_read, mem_write, mem_addr and mem_wdata.

## Timing
- Reset values: state IDLE, all acks 0, busy 0, all mem_* outputs 0, both rdata 0, last_grant = port 1 (so port 0 wins the first contended arbitration).
- Latency: req high in IDLE cycle T gives ACCESS in T+1, ack and rdata valid in T+2. The FSM is back in IDLE at T+3.
- Throughput: one access per 3 cycles. Back-to-back alternating grants when both ports hold req.
- A req rising during ACCESS or RESP waits for the next IDLE.
- rst asserted in ACCESS: at that edge the FSM goes to IDLE and no ack is issued. A write with mem_write high in that cycle still commits in memory. Read data is not captured.
- rst asserted in RESP: ack is dropped from the next cycle. rdata already captured is cleared to 0.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin arbitration as above.
- DMEM_ARB_RR_EN undefined: fixed priority, where port 0 always wins a contended IDLE. last_grant logic is removed. Port 1 is served only in an IDLE where r0_req is low.

## Test plan
- Single write then read, port 0: write addr 2, data 0x12345678, then read addr 2. Write: r0_ack high 2 cycles after req, mem_write high only in ACCESS. Read: r0_rdata = 0x12345678 with r0_ack, r1_ack stays 0.
- Contention: both ports request reads at reset-exit (r0 addr 3, r1 addr 4, preloaded 0x87654321 / 0x0000BEEF). With DMEM_ARB_RR_EN, r0_ack at T+2 with 0x87654321, then r1_ack at T+5 with 0x0000BEEF.
- Fixed priority: DMEM_ARB_RR_EN undefined, r0_req held through 3 transactions with r1_req continuously high. Three r0 acks, no r1_ack until r0_req drops.
- Field change after grant: r1 write addr 5, data 0xA5A5A5A5, changed to addr 6 in the ACCESS cycle. Mem[5] = 0xA5A5A5A5, Mem[6] unchanged.
- Reset mid-ACCESS on a port 0 read: no r0_ack, r0_rdata = 0. The FSM returns to IDLE and the next request completes normally.
- Exclusivity check: random traffic for 1000 cycles. mem_read and mem_write are never both 1, and at most one ack is high per cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// -----------------------------------------------------------------------------
// Two-requester arbiter and sequencer for the 64-word x 32-bit data memory.
// Port 0 is the CPU load/store path and port 1 is the debug/loader port. One
// requester is granted at a time. Each access takes three cycles:
// IDLE (grant) -> ACCESS (memory driven) -> RESP (ack pulse).
//
// Build option:
//   DMEM_ARB_RR_EN  defined   : round-robin between contending ports
//                   undefined : fixed priority, port 0 always wins
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   r0_req / r1_req       request, held until the matching ack
//   r0_we / r1_we         1 = write, 0 = read (sampled at grant)
//   r0_addr / r1_addr     word address (sampled at grant)
//   r0_wdata / r1_wdata   write data (sampled at grant)
//   r0_ack / r1_ack       one-cycle completion pulse
//   r0_rdata / r1_rdata   read result, held until that port's next read
//   mem_read, mem_write   memory enables, only ever high in ACCESS
//   mem_addr, mem_wdata   memory address / write data, zero outside ACCESS
//   mem_rdata             combinational read data from the memory
//   busy                  high in ACCESS and RESP
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Port being served by the access in flight (0 or 1).
    logic grant_port;

    // Combinational grant decision, only meaningful in IDLE.
    logic grant_valid;
    logic grant_sel;

`ifdef DMEM_ARB_RR_EN
    // Port granted most recently; the other port wins the next contended IDLE.
    logic last_grant;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and grant selection.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        case (state)
            IDLE: begin
                if (r0_req || r1_req) begin
                    grant_valid = 1'b1;
                    state_next  = ACCESS;
`ifdef DMEM_ARB_RR_EN
                    if (r0_req && r1_req) begin
                        grant_sel = ~last_grant;
                    end else begin
                        grant_sel = r1_req;
                    end
`else
                    grant_sel = ~r0_req;
`endif
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef DMEM_ARB_RR_EN
    // Reset to port 1 so port 0 wins the first contended arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_valid) begin
            last_grant <= grant_sel;
        end
    end
`endif

    // Datapath. The memory-side registers are loaded at the grant edge and
    // cleared at the edge leaving ACCESS, so they are nonzero only in ACCESS.
    // The ack register is set at the edge leaving ACCESS, so it is high in RESP.
    // A reset at the edge leaving ACCESS suppresses both the ack and the
    // read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_port <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            r0_ack     <= 1'b0;
            r1_ack     <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            r0_ack    <= 1'b0;
            r1_ack    <= 1'b0;
            if (grant_valid) begin
                grant_port <= grant_sel;
                if (grant_sel) begin
                    mem_read  <= ~r1_we;
                    mem_write <= r1_we;
                    mem_addr  <= r1_addr;
                    mem_wdata <= r1_wdata;
                end else begin
                    mem_read  <= ~r0_we;
                    mem_write <= r0_we;
                    mem_addr  <= r0_addr;
                    mem_wdata <= r0_wdata;
                end
            end
            if (state == ACCESS) begin
                if (grant_port) begin
                    r1_ack <= 1'b1;
                    if (mem_read) begin
                        r1_rdata <= mem_rdata;
                    end
                end else begin
                    r0_ack <= 1'b1;
                    if (mem_read) begin
                        r0_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
